// File: rtl/res_station_pkg.sv
// rtl/res_station_pkg.sv - reservation station sizes, tag width and record types
// Shared by the reservation station, its interface and the testbench.
package res_station_pkg;

  localparam int RS_DEPTH = 4;
  localparam int OP_WIDTH = 6;
  localparam int ROB_SIZE = 5;

  typedef logic [ROB_SIZE-1:0] rob_tag_t;

  typedef struct packed {
    logic [OP_WIDTH-1:0] op;
    logic [31:0]         vj;
    rob_tag_t            qj;
    logic                qj_wait;
    logic [31:0]         vk;
    rob_tag_t            qk;
    logic                qk_wait;
    rob_tag_t            rob_tag;
  } issue_rs_struct_o;

  typedef struct packed {
    logic        valid;
    rob_tag_t    tag;
    logic [31:0] value;
    logic        br_taken;
  } cdb_struct_t;

  typedef struct packed {
    logic [OP_WIDTH-1:0] op;
    logic [31:0]         vj;
    logic [31:0]         vk;
    rob_tag_t            rob_tag;
  } rs_fu_struct_o;

  typedef struct packed {
    logic                busy;
    logic [OP_WIDTH-1:0] op;
    logic [31:0]         vj;
    rob_tag_t            qj;
    logic                qj_wait;
    logic [31:0]         vk;
    rob_tag_t            qk;
    logic                qk_wait;
    rob_tag_t            rob_tag;
  } rs_entry_t;

  function automatic rs_fu_struct_o entry_to_fu(input rs_entry_t e);
    rs_fu_struct_o f;
    f.op      = e.op;
    f.vj      = e.vj;
    f.vk      = e.vk;
    f.rob_tag = e.rob_tag;
    return f;
  endfunction

endpackage

// File: rtl/res_station_if.sv
// rtl/res_station_if.sv - issue, CDB and FU-dispatch signals of the reservation station
// slave is the station's view; master is the pipeline/testbench view.
interface res_station_if;
  import res_station_pkg::*;

  logic             issue_valid_i;
  issue_rs_struct_o issue_data_i;
  cdb_struct_t      cdb_data_i;
  logic             fu_ready_i;
  logic             fu_valid_o;
  rs_fu_struct_o    fu_data_o;
  logic             full_o;

  modport slave (
    input  issue_valid_i, issue_data_i, cdb_data_i, fu_ready_i,
    output fu_valid_o, fu_data_o, full_o
  );

  modport master (
    output issue_valid_i, issue_data_i, cdb_data_i, fu_ready_i,
    input  fu_valid_o, fu_data_o, full_o
  );

endinterface

// File: rtl/rs_pick.sv
// rtl/rs_pick.sv - lowest-index priority encoder with one-hot grant and any flag
module rs_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt,
  output logic         o_any
);

  // req & -req isolates the lowest set bit
  assign o_gnt = i_req & (~i_req + N'(1));
  assign o_any = |i_req;

endmodule

// File: rtl/res_station.sv
// rtl/res_station.sv - reservation station feeding one functional unit
// Holds issued ops until operands arrive on the CDB, then dispatches through a registered output.
module res_station
  import res_station_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush_i,
  res_station_if.slave   rs_if
);

  rs_entry_t        r_ent [DEPTH];
  logic             r_fu_valid;
  rs_fu_struct_o    r_fu_data;

  logic [DEPTH-1:0] w_busy;
  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_free_gnt;
  logic [DEPTH-1:0] w_sel_gnt;
  logic             w_free_any;
  logic             w_sel_any;
  logic             w_full;
  logic             w_load;
  logic             w_alloc;
  rs_entry_t        w_new;
  rs_fu_struct_o    w_sel_data;
  cdb_struct_t      w_cdb;
  logic             w_unused;

  assign w_cdb    = rs_if.cdb_data_i;
  assign w_unused = w_cdb.br_taken;

  always_comb begin
    w_busy  = '0;
    w_ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_busy[i]  = r_ent[i].busy;
      w_ready[i] = r_ent[i].busy && !r_ent[i].qj_wait && !r_ent[i].qk_wait;
    end
  end

  rs_pick #(.N(DEPTH)) u_free_pick (
    .i_req (~w_busy),
    .o_gnt (w_free_gnt),
    .o_any (w_free_any)
  );

  rs_pick #(.N(DEPTH)) u_sel_pick (
    .i_req (w_ready),
    .o_gnt (w_sel_gnt),
    .o_any (w_sel_any)
  );

  // full is from busy bits only, so a slot freed by select this cycle is not offered
  assign w_full  = &w_busy;
  assign w_load  = !r_fu_valid || rs_if.fu_ready_i;
  assign w_alloc = rs_if.issue_valid_i && !w_full && w_free_any;

  always_comb begin
    w_new.busy    = 1'b1;
    w_new.op      = rs_if.issue_data_i.op;
    w_new.vj      = rs_if.issue_data_i.vj;
    w_new.qj      = rs_if.issue_data_i.qj;
    w_new.qj_wait = rs_if.issue_data_i.qj_wait;
    w_new.vk      = rs_if.issue_data_i.vk;
    w_new.qk      = rs_if.issue_data_i.qk;
    w_new.qk_wait = rs_if.issue_data_i.qk_wait;
    w_new.rob_tag = rs_if.issue_data_i.rob_tag;
    if (w_cdb.valid && rs_if.issue_data_i.qj_wait && rs_if.issue_data_i.qj == w_cdb.tag) begin
      w_new.vj      = w_cdb.value;
      w_new.qj_wait = 1'b0;
    end
    if (w_cdb.valid && rs_if.issue_data_i.qk_wait && rs_if.issue_data_i.qk == w_cdb.tag) begin
      w_new.vk      = w_cdb.value;
      w_new.qk_wait = 1'b0;
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel_gnt[i]) begin
        w_sel_data = w_sel_data | entry_to_fu(r_ent[i]);
      end
    end
  end

  // select only targets busy entries and alloc only free ones, so the branches never collide
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= '0;
      end
      r_fu_valid <= 1'b0;
      r_fu_data  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_load && w_sel_gnt[i]) begin
          r_ent[i].busy <= 1'b0;
        end else if (w_alloc && w_free_gnt[i]) begin
          r_ent[i] <= w_new;
        end else if (r_ent[i].busy && w_cdb.valid) begin
          if (r_ent[i].qj_wait && r_ent[i].qj == w_cdb.tag) begin
            r_ent[i].vj      <= w_cdb.value;
            r_ent[i].qj_wait <= 1'b0;
          end
          if (r_ent[i].qk_wait && r_ent[i].qk == w_cdb.tag) begin
            r_ent[i].vk      <= w_cdb.value;
            r_ent[i].qk_wait <= 1'b0;
          end
        end
      end
      if (w_load) begin
        r_fu_valid <= w_sel_any;
        if (w_sel_any) begin
          r_fu_data <= w_sel_data;
        end
      end
    end
  end

  assign rs_if.fu_valid_o = r_fu_valid;
  assign rs_if.fu_data_o  = r_fu_data;
  assign rs_if.full_o     = w_full;

endmodule

// File: tb/tb_res_station.sv
// tb/tb_res_station.sv - self-checking bench for res_station
// Vector table plus hand sequences; dispatches are checked against a scoreboard queue.
module tb_res_station;
  import res_station_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush_i;

  always #5 clk = ~clk;

  res_station_if rs_if ();

  res_station #(.DEPTH(RS_DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .rs_if   (rs_if.slave)
  );

  typedef struct {
    issue_rs_struct_o iss;
    cdb_struct_t      cdb;
    rs_fu_struct_o    want;
  } vec_t;

  int            checks   = 0;
  int            failures = 0;
  int            disp_cnt = 0;
  rs_fu_struct_o exp_q [$];
  rs_fu_struct_o mon_want;
  vec_t          vecs [5];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  function automatic issue_rs_struct_o mk_issue(input logic [OP_WIDTH-1:0] op,
      input logic [31:0] vj, input logic jw, input rob_tag_t qj,
      input logic [31:0] vk, input logic kw, input rob_tag_t qk, input rob_tag_t tag);
    issue_rs_struct_o s;
    s.op = op; s.vj = vj; s.qj_wait = jw; s.qj = qj;
    s.vk = vk; s.qk_wait = kw; s.qk = qk; s.rob_tag = tag;
    return s;
  endfunction

  function automatic cdb_struct_t mk_cdb(input logic v, input rob_tag_t tag,
      input logic [31:0] value, input logic bt);
    cdb_struct_t c;
    c.valid = v; c.tag = tag; c.value = value; c.br_taken = bt;
    return c;
  endfunction

  function automatic rs_fu_struct_o mk_fu(input logic [OP_WIDTH-1:0] op,
      input logic [31:0] vj, input logic [31:0] vk, input rob_tag_t tag);
    rs_fu_struct_o f;
    f.op = op; f.vj = vj; f.vk = vk; f.rob_tag = tag;
    return f;
  endfunction

  // scoreboard: every accepted output must be the next queued expectation
  always @(negedge clk) begin
    if (!rst && rs_if.fu_valid_o === 1'b1 && rs_if.fu_ready_i === 1'b1) begin
      disp_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_dispatch: got tag %0d required none", rs_if.fu_data_o.rob_tag);
      end else begin
        mon_want = exp_q.pop_front();
        chk("dispatch", 128'(rs_if.fu_data_o), 128'(mon_want));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rs_if.issue_valid_i = 1'b0;
    rs_if.issue_data_i  = '0;
    rs_if.cdb_data_i    = '0;
  endtask

  task automatic issue(input issue_rs_struct_o s);
    rs_if.issue_valid_i = 1'b1;
    rs_if.issue_data_i  = s;
    tick();
    rs_if.issue_valid_i = 1'b0;
    rs_if.issue_data_i  = '0;
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    chk(name, 128'(exp_q.size()), 128'(0));
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{mk_issue(1, 5, 0, 0, 7, 0, 0, 3),         mk_cdb(0, 0, 0, 0),        mk_fu(1, 5, 7, 3)};
    vecs[1] = '{mk_issue(2, 11, 0, 0, 0, 1, 2, 4),        mk_cdb(1, 2, 42, 0),       mk_fu(2, 11, 42, 4)};
    vecs[2] = '{mk_issue(3, 0, 1, 6, 8, 0, 0, 7),         mk_cdb(1, 6, 32'hdead, 1), mk_fu(3, 32'hdead, 8, 7)};
    vecs[3] = '{mk_issue(4, 0, 1, 1, 0, 1, 1, 9),         mk_cdb(1, 1, 99, 0),       mk_fu(4, 99, 99, 9)};
    vecs[4] = '{mk_issue(5, 1, 0, 12, 2, 0, 12, 11),      mk_cdb(1, 12, 555, 0),     mk_fu(5, 1, 2, 11)};

    rst = 1'b1;
    flush_i = 1'b0;
    idle();
    rs_if.fu_ready_i = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", 128'(rs_if.fu_valid_o), 128'(0));
    chk("rst_full",  128'(rs_if.full_o), 128'(0));
    chk("rst_data",  128'(rs_if.fu_data_o), 128'(0));
    tick();
    rst = 1'b0;

    // two-edge latency for a ready issue
    rs_if.fu_ready_i = 1'b1;
    exp_q.push_back(mk_fu(1, 5, 7, 3));
    issue(mk_issue(1, 5, 0, 0, 7, 0, 0, 3));
    @(negedge clk);
    chk("lat_e0", 128'(rs_if.fu_valid_o), 128'(0));
    tick();
    @(negedge clk);
    chk("lat_e1", 128'(rs_if.fu_valid_o), 128'(1));
    wait_drain("lat_drain");

    for (int i = 0; i < 5; i++) begin
      rs_if.issue_valid_i = 1'b1;
      rs_if.issue_data_i  = vecs[i].iss;
      rs_if.cdb_data_i    = vecs[i].cdb;
      exp_q.push_back(vecs[i].want);
      tick();
      idle();
      wait_drain($sformatf("vec%0d", i));
    end

    // wakeup one edge after the broadcast
    exp_q.push_back(mk_fu(2, 32'h1234, 3, 5));
    issue(mk_issue(2, 0, 1, 9, 3, 0, 0, 5));
    @(negedge clk);
    chk("wake_pre", 128'(rs_if.fu_valid_o), 128'(0));
    rs_if.cdb_data_i = mk_cdb(1, 9, 32'h1234, 0);
    tick();
    rs_if.cdb_data_i = '0;
    @(negedge clk);
    chk("wake_w", 128'(rs_if.fu_valid_o), 128'(0));
    tick();
    @(negedge clk);
    chk("wake_w1", 128'(rs_if.fu_valid_o), 128'(1));
    wait_drain("wake_drain");

    // non-matching tag leaves both operands waiting; one broadcast wakes both
    issue(mk_issue(3, 0, 1, 4, 0, 1, 4, 6));
    rs_if.cdb_data_i = mk_cdb(1, 5, 1, 0);
    tick();
    rs_if.cdb_data_i = '0;
    repeat (2) tick();
    @(negedge clk);
    chk("nomatch_hold", 128'(rs_if.fu_valid_o), 128'(0));
    exp_q.push_back(mk_fu(3, 77, 77, 6));
    rs_if.cdb_data_i = mk_cdb(1, 4, 77, 0);
    tick();
    rs_if.cdb_data_i = '0;
    wait_drain("both_wake");

    // backpressure: first op sits in the output register, four more fill the entries
    rs_if.fu_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) issue(mk_issue(4, 100 + k, 0, 0, 200 + k, 0, 0, rob_tag_t'(10 + k)));
    @(negedge clk);
    chk("full_after5", 128'(rs_if.full_o), 128'(1));
    chk("hold_tag0", 128'(rs_if.fu_data_o.rob_tag), 128'(10));
    issue(mk_issue(4, 999, 0, 0, 999, 0, 0, 15));
    @(negedge clk);
    chk("full_hold", 128'(rs_if.full_o), 128'(1));
    chk("hold_valid", 128'(rs_if.fu_valid_o), 128'(1));
    chk("hold_tag1", 128'(rs_if.fu_data_o), 128'(mk_fu(4, 100, 200, 10)));
    // entries were filled e1=t11, e0=t12, e2=t13, e3=t14; drain is by index
    exp_q.push_back(mk_fu(4, 100, 200, 10));
    exp_q.push_back(mk_fu(4, 102, 202, 12));
    exp_q.push_back(mk_fu(4, 101, 201, 11));
    exp_q.push_back(mk_fu(4, 103, 203, 13));
    exp_q.push_back(mk_fu(4, 104, 204, 14));
    tick();
    disp_cnt = 0;
    rs_if.fu_ready_i = 1'b1;
    repeat (5) tick();
    chk("throughput", 128'(disp_cnt), 128'(5));
    chk("drain_valid", 128'(rs_if.fu_valid_o), 128'(0));
    chk("drain_full", 128'(rs_if.full_o), 128'(0));
    wait_drain("drain_q");

    // flush with a simultaneous issue
    rs_if.fu_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) issue(mk_issue(5, 300 + k, 0, 0, 400 + k, 0, 0, rob_tag_t'(20 + k)));
    @(negedge clk);
    chk("pre_flush_valid", 128'(rs_if.fu_valid_o), 128'(1));
    flush_i = 1'b1;
    issue(mk_issue(5, 1, 0, 0, 1, 0, 0, 24));
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_valid", 128'(rs_if.fu_valid_o), 128'(0));
    chk("flush_full",  128'(rs_if.full_o), 128'(0));
    chk("flush_data",  128'(rs_if.fu_data_o), 128'(0));
    rs_if.fu_ready_i = 1'b1;
    repeat (4) tick();
    chk("flush_quiet", 128'(rs_if.fu_valid_o), 128'(0));

    // reset while an operand is pending
    issue(mk_issue(6, 0, 1, 7, 2, 0, 0, 8));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rs_if.cdb_data_i = mk_cdb(1, 7, 1, 0);
    tick();
    rs_if.cdb_data_i = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_wait_valid", 128'(rs_if.fu_valid_o), 128'(0));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
